// File: rtl/song_note_sequencer_if.sv
// Bus between the note sequencer, the song ROM and the game controller.
//   start_in          1-cycle start request (controller -> sequencer)
//   song_sel_in       song number, sampled with an accepted start
//   player_note_in    player note, 0 = none
//   rom_addr_out      {song, index} to the song ROM
//   rom_data_in       ROM note: 0 = rest, 7'h7F = end marker, else pitch
//   current_notes_out 5-note window, [34:28] is the note playing now
//   score_out         hits in the current/last song (saturating)
//   beat_out          1-cycle pulse per beat boundary
//   busy_out          song in progress
//   done_out          1-cycle pulse when the song finishes
interface song_note_sequencer_if #(
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned SCORE_W = 12
);
  logic               start_in;
  logic [1:0]         song_sel_in;
  logic [6:0]         player_note_in;
  logic [IDX_W+1:0]   rom_addr_out;
  logic [6:0]         rom_data_in;
  logic [34:0]        current_notes_out;
  logic [SCORE_W-1:0] score_out;
  logic               beat_out;
  logic               busy_out;
  logic               done_out;

  modport slave (
    input  start_in, song_sel_in, player_note_in, rom_data_in,
    output rom_addr_out, current_notes_out, score_out, beat_out, busy_out, done_out
  );

  modport master (
    output start_in, song_sel_in, player_note_in, rom_data_in,
    input  rom_addr_out, current_notes_out, score_out, beat_out, busy_out, done_out
  );
endinterface

// File: rtl/song_note_sequencer.sv
// Song note sequencer: fetches notes of the selected song from the song ROM
// into a 5-note look-ahead window plus a one-note prefetch register, shifts
// the window once per beat and scores player hits against the head note.
// Ports:
//   clk_in  system clock
//   rst_in  synchronous active-high reset
//   bus     song_note_sequencer_if.slave (start/select/player in, ROM port,
//           window, score, beat/busy/done status out)
module song_note_sequencer #(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned ROM_LATENCY = 2,
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned SCORE_W     = 12
) (
  input  logic clk_in,
  input  logic rst_in,
  song_note_sequencer_if.slave bus
);

  localparam int unsigned BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int unsigned LAT_W  = $clog2(ROM_LATENCY + 1);
  localparam logic [6:0]  MARKER = 7'h7F;

  typedef enum logic [1:0] {IDLE, PRELOAD, PLAY, DONE} state_t;

  state_t             state;
  logic [1:0]         song;
  logic [IDX_W-1:0]   idx;
  logic [4:0]         vmask;
  logic [6:0]         prefetch;
  logic               pvalid;
  logic               ended;
  logic               fetching;
  logic               fetch_req;
  logic [LAT_W-1:0]   wait_cnt;
  logic [2:0]         loaded;
  logic [BEAT_W-1:0]  beat_cnt;
  logic               hit;

  logic [6:0] head;
  logic       hit_now;
  logic       tick;
  logic       is_marker;
  logic [4:0] vmask_next;

  always_comb begin
    head       = bus.current_notes_out[34:28];
    hit_now    = vmask[4] && (head != '0) && (bus.player_note_in == head);
    tick       = (state == PLAY) && (beat_cnt == BEAT_W'(BEAT_CYCLES - 1));
    is_marker  = (bus.rom_data_in == MARKER);
    vmask_next = {vmask[3:0], pvalid};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                 <= IDLE;
      song                  <= '0;
      idx                   <= '0;
      vmask                 <= '0;
      prefetch              <= '0;
      pvalid                <= 1'b0;
      ended                 <= 1'b0;
      fetching              <= 1'b0;
      fetch_req             <= 1'b0;
      wait_cnt              <= '0;
      loaded                <= '0;
      beat_cnt              <= '0;
      hit                   <= 1'b0;
      bus.rom_addr_out      <= '0;
      bus.current_notes_out <= '0;
      bus.score_out         <= '0;
      bus.beat_out          <= 1'b0;
      bus.busy_out          <= 1'b0;
      bus.done_out          <= 1'b0;
    end else begin
      bus.beat_out <= 1'b0;
      bus.done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            song                  <= bus.song_sel_in;
            idx                   <= '0;
            vmask                 <= '0;
            prefetch              <= '0;
            pvalid                <= 1'b0;
            ended                 <= 1'b0;
            fetching              <= 1'b0;
            fetch_req             <= 1'b0;
            loaded                <= '0;
            hit                   <= 1'b0;
            bus.current_notes_out <= '0;
            bus.score_out         <= '0;
            bus.busy_out          <= 1'b1;
            state                 <= PRELOAD;
          end
        end

        // Window and prefetch form one 6-deep shift chain: every loaded note
        // enters the prefetch slot and pushes the chain up by one, so after
        // six loads the first note sits at the head.
        PRELOAD: begin
          if (fetching) begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - LAT_W'(1);
            end else begin
              fetching              <= 1'b0;
              loaded                <= loaded + 3'd1;
              bus.current_notes_out <= {bus.current_notes_out[27:0], prefetch};
              vmask                 <= vmask_next;
              if (is_marker) begin
                prefetch <= '0;
                pvalid   <= 1'b0;
                ended    <= 1'b1;
              end else begin
                prefetch <= bus.rom_data_in;
                pvalid   <= 1'b1;
                if (idx == '1) ended <= 1'b1;
                else           idx   <= idx + IDX_W'(1);
              end
              if (loaded == 3'd5) begin
                state    <= PLAY;
                beat_cnt <= '0;
              end
              if (is_marker && idx == '0) begin
                state        <= DONE;
                bus.done_out <= 1'b1;
                bus.busy_out <= 1'b0;
              end
            end
          end else if (ended) begin
            // Song ended early: pad the rest of the chain with invalid rests.
            loaded                <= loaded + 3'd1;
            bus.current_notes_out <= {bus.current_notes_out[27:0], prefetch};
            vmask                 <= vmask_next;
            prefetch              <= '0;
            pvalid                <= 1'b0;
            if (loaded == 3'd5) begin
              state    <= PLAY;
              beat_cnt <= '0;
            end
          end else begin
            bus.rom_addr_out <= {song, idx};
            fetching         <= 1'b1;
            wait_cnt         <= LAT_W'(ROM_LATENCY);
          end
        end

        PLAY: begin
          beat_cnt <= tick ? '0 : beat_cnt + BEAT_W'(1);
          if (hit_now) hit <= 1'b1;

          if (fetch_req) begin
            fetch_req        <= 1'b0;
            bus.rom_addr_out <= {song, idx};
            fetching         <= 1'b1;
            wait_cnt         <= LAT_W'(ROM_LATENCY);
          end else if (fetching) begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - LAT_W'(1);
            end else begin
              fetching <= 1'b0;
              if (is_marker) begin
                prefetch <= '0;
                pvalid   <= 1'b0;
                ended    <= 1'b1;
              end else begin
                prefetch <= bus.rom_data_in;
                pvalid   <= 1'b1;
                if (idx == '1) ended <= 1'b1;
                else           idx   <= idx + IDX_W'(1);
              end
            end
          end

          // The tick cycle's own match still counts for the ending beat.
          if (tick) begin
            bus.beat_out <= 1'b1;
            if ((hit || hit_now) && bus.score_out != '1)
              bus.score_out <= bus.score_out + SCORE_W'(1);
            hit                   <= 1'b0;
            bus.current_notes_out <= {bus.current_notes_out[27:0], prefetch};
            vmask                 <= vmask_next;
            prefetch              <= '0;
            pvalid                <= 1'b0;
            if (!ended) fetch_req <= 1'b1;
            if (vmask_next == '0) begin
              state        <= DONE;
              bus.done_out <= 1'b1;
              bus.busy_out <= 1'b0;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_note_sequencer.sv
module tb_song_note_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  song_note_sequencer_if #(.IDX_W(8), .SCORE_W(12)) ifc ();
  song_note_sequencer_if #(.IDX_W(8), .SCORE_W(2))  ifc2 ();

  song_note_sequencer #(.BEAT_CYCLES(8), .ROM_LATENCY(2), .IDX_W(8), .SCORE_W(12)) dut (
    .clk_in(clk), .rst_in(rst), .bus(ifc.slave));
  song_note_sequencer #(.BEAT_CYCLES(8), .ROM_LATENCY(2), .IDX_W(8), .SCORE_W(2)) dut2 (
    .clk_in(clk), .rst_in(rst), .bus(ifc2.slave));

  int errors = 0;
  int checks = 0;
  int beats = 0, dones = 0, beats2 = 0, dones2 = 0;

  typedef struct {
    logic [34:0] notes;
    logic [11:0] score;
  } exp_t;
  exp_t q[$];
  exp_t q2[$];

  // Song table: notes before the end marker
  function automatic int song_len(input int sel);
    case (sel)
      0: return 7;
      1: return 3;
      2: return 0;
      default: return 7;
    endcase
  endfunction

  function automatic logic [6:0] note_at(input int sel, input int k);
    if (k < 0 || k >= song_len(sel)) return 7'd0;
    case (sel)
      0: return 7'(k + 1);
      1: return (k == 0) ? 7'd10 : (k == 1) ? 7'd20 : 7'd30;
      3: return (k < 5) ? 7'd5 : 7'd0;
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [6:0] rom_val(input logic [9:0] a);
    int sel = int'(a[9:8]);
    int k   = int'(a[7:0]);
    if (k < song_len(sel)) return note_at(sel, k);
    return 7'h7F;
  endfunction

  // Two-cycle latency ROM models
  logic [6:0] r1, r1b;
  always @(posedge clk) begin
    r1              <= rom_val(ifc.rom_addr_out);
    ifc.rom_data_in <= r1;
    r1b              <= rom_val(ifc2.rom_addr_out);
    ifc2.rom_data_in <= r1b;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard model: after beat k the head is note k, score counts heads matched
  task automatic push_song(input int sel, input logic [6:0] player, input int smax, input bit to2);
    int sc;
    logic [6:0] h;
    exp_t e;
    sc = 0;
    for (int k = 1; k <= song_len(sel); k++) begin
      h = note_at(sel, k - 1);
      if (h != 7'd0 && h == player && sc < smax) sc++;
      e.notes = {note_at(sel, k), note_at(sel, k + 1), note_at(sel, k + 2),
                 note_at(sel, k + 3), note_at(sel, k + 4)};
      e.score = 12'(sc);
      if (to2) q2.push_back(e);
      else     q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ifc.beat_out) begin
      beats++;
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat: observed=beat expected=none");
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        assert (ifc.current_notes_out === e.notes) else begin
          errors++;
          $error("FAIL beat_window: observed=%0h expected=%0h", ifc.current_notes_out, e.notes);
        end
        checks++;
        assert (ifc.score_out === e.score) else begin
          errors++;
          $error("FAIL beat_score: observed=%0d expected=%0d", ifc.score_out, e.score);
        end
      end
    end
    if (ifc.done_out) dones++;
    if (ifc2.beat_out) begin
      beats2++;
      checks++;
      assert (q2.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat2: observed=beat expected=none");
      end
      if (q2.size() != 0) begin
        e = q2.pop_front();
        checks++;
        assert ({10'd0, ifc2.score_out} === e.score) else begin
          errors++;
          $error("FAIL beat_score2: observed=%0d expected=%0d", ifc2.score_out, e.score);
        end
      end
    end
    if (ifc2.done_out) dones2++;
  end

  task automatic start_song(input int sel, input bit both);
    @(negedge clk);
    ifc.start_in    = 1'b1;
    ifc.song_sel_in = 2'(sel);
    if (both) begin
      ifc2.start_in    = 1'b1;
      ifc2.song_sel_in = 2'(sel);
    end
    @(negedge clk);
    ifc.start_in  = 1'b0;
    ifc2.start_in = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string tag);
    int n = 0;
    while (dones == prev && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(dones != prev), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  64'(ifc.busy_out), 64'd0);
    chk({tag, "_done"},  64'(ifc.done_out), 64'd0);
    chk({tag, "_beat"},  64'(ifc.beat_out), 64'd0);
    chk({tag, "_score"}, 64'(ifc.score_out), 64'd0);
    chk({tag, "_notes"}, 64'(ifc.current_notes_out), 64'd0);
    chk({tag, "_addr"},  64'(ifc.rom_addr_out), 64'd0);
  endtask

  initial begin
    int b0, d0, n;
    rst = 1'b1;
    ifc.start_in = 1'b0;  ifc.song_sel_in = '0;  ifc.player_note_in = '0;
    ifc2.start_in = 1'b0; ifc2.song_sel_in = '0; ifc2.player_note_in = '0;

    // 1: reset, with start during reset ignored
    repeat (2) @(negedge clk);
    ifc.start_in = 1'b1;
    @(negedge clk);
    ifc.start_in = 1'b0;
    rst = 1'b0;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    chk("start_in_reset_ignored", 64'(ifc.busy_out), 64'd0);

    // 2: song1 {10,20,30}, player 10
    ifc.player_note_in = 7'd10;
    push_song(1, 7'd10, 4095, 1'b0);
    b0 = beats; d0 = dones;
    start_song(1, 1'b0);
    chk("busy_after_start", 64'(ifc.busy_out), 64'd1);
    n = 0;
    while (ifc.rom_addr_out == 10'h000 && n < 20) begin @(negedge clk); n++; end
    chk("rom_addr_first", 64'(ifc.rom_addr_out), 64'h100);
    n = 0;
    while (ifc.rom_addr_out == 10'h100 && n < 20) begin @(negedge clk); n++; end
    chk("rom_addr_second", 64'(ifc.rom_addr_out), 64'h101);
    wait_done(d0, "song1_done_timeout");
    chk("song1_beats", 64'(beats - b0), 64'd3);
    chk("song1_score", 64'(ifc.score_out), 64'd1);
    chk("song1_busy_after_done", 64'(ifc.busy_out), 64'd0);
    chk("song1_queue_empty", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("song1_score_held", 64'(ifc.score_out), 64'd1);

    // 3: song0 1..7, player 3, start during PLAY ignored
    ifc.player_note_in = 7'd3;
    push_song(0, 7'd3, 4095, 1'b0);
    b0 = beats; d0 = dones;
    start_song(0, 1'b0);
    n = 0;
    while (beats == b0 && n < 200) begin @(negedge clk); n++; end
    start_song(2, 1'b0);
    wait_done(d0, "song0_done_timeout");
    chk("song0_beats", 64'(beats - b0), 64'd7);
    chk("song0_score", 64'(ifc.score_out), 64'd1);
    chk("song0_queue_empty", 64'(q.size()), 64'd0);

    // 4: song2 starts with marker
    b0 = beats; d0 = dones;
    start_song(2, 1'b0);
    wait_done(d0, "song2_done_timeout");
    chk("song2_beats", 64'(beats - b0), 64'd0);
    chk("song2_score", 64'(ifc.score_out), 64'd0);
    chk("song2_busy", 64'(ifc.busy_out), 64'd0);

    // 5: song3 {5,5,5,5,5,0,0}: saturation on the 2-bit instance
    ifc.player_note_in  = 7'd5;
    ifc2.player_note_in = 7'd5;
    push_song(3, 7'd5, 4095, 1'b0);
    push_song(3, 7'd5, 3, 1'b1);
    b0 = beats2; d0 = dones;
    start_song(3, 1'b1);
    wait_done(d0, "song3_done_timeout");
    n = 0;
    while (dones2 == 0 && n < 20) begin @(negedge clk); n++; end
    chk("song3_dut2_done", 64'(dones2), 64'd1);
    chk("song3_score", 64'(ifc.score_out), 64'd5);
    chk("song3_score_sat", 64'(ifc2.score_out), 64'd3);
    chk("song3_dut2_beats", 64'(beats2 - b0), 64'd7);
    // rest heads with player=0 never score
    ifc.player_note_in = 7'd0;
    push_song(3, 7'd0, 4095, 1'b0);
    d0 = dones;
    start_song(3, 1'b0);
    wait_done(d0, "song3_rest_done_timeout");
    chk("song3_rest_score", 64'(ifc.score_out), 64'd0);

    // 6: reset in beat 2
    ifc.player_note_in = 7'd1;
    push_song(0, 7'd1, 4095, 1'b0);
    b0 = beats; d0 = dones;
    start_song(0, 1'b0);
    n = 0;
    while (beats == b0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check_idle_outputs("midsong_reset");
    b0 = beats;
    repeat (60) @(negedge clk);
    chk("midsong_reset_no_done", 64'(dones - d0), 64'd0);
    chk("midsong_reset_no_beat", 64'(beats - b0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
